// File: rtl/uart_tx_arb.sv
// Purpose : two-requester byte arbiter in front of a UART transmitter, with packet-level grants.
// Latency : grant is registered one cycle after a valid in IDLE; tx_start/tx_byte are registered on the transfer edge.
// Backpres: reqN_ready follows tx_ready while granted in SEND; tx_start/tx_byte hold until tx_accept.
//
// Ports:
//   clk, rst                 - system clock, async active-high reset
//   reqN_valid/byte/last     - requester N byte stream (N = 0, 1)
//   reqN_ready               - combinational accept strobe to requester N
//   tx_start, tx_byte        - registered byte-load request to the transmitter
//   tx_ready, tx_accept      - transmitter idle flag and one-cycle latch pulse
//   grant                    - one-hot current owner (bit0 = req0), 00 when free
//   pkt_abort                - one-cycle pulse when a stalled packet is revoked
module uart_tx_arb #(
  parameter int MAX_LEN = 64,
  parameter int GAP_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  input  logic       tx_accept,
  output logic [1:0] grant,
  output logic       pkt_abort
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACC} state_t;

  localparam logic [7:0]  MaxLenC = 8'(MAX_LEN);
  // The abort fires on the edge where the counter would reach GAP_MAX.
  localparam logic [15:0] GapLimC = 16'(GAP_MAX - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        prio_q, prio_d;       // 1: req1 wins a tie, 0: req0 wins a tie
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        pkt_abort_q, pkt_abort_d;
  logic        last_q, last_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_q, gap_d;

  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_byte;
  logic        xfer;

  // Mux of the granted requester; grant is one-hot so bit1 alone selects.
  assign sel_valid = grant_q[1] ? req1_valid : req0_valid;
  assign sel_last  = grant_q[1] ? req1_last  : req0_last;
  assign sel_byte  = grant_q[1] ? req1_byte  : req0_byte;

  assign req0_ready = ~rst & (state_q == SEND) & grant_q[0] & tx_ready;
  assign req1_ready = ~rst & (state_q == SEND) & grant_q[1] & tx_ready;
  assign xfer       = (state_q == SEND) & sel_valid & tx_ready;

  assign tx_start  = tx_start_q;
  assign tx_byte   = tx_byte_q;
  assign grant     = grant_q;
  assign pkt_abort = pkt_abort_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    tx_start_d  = tx_start_q;
    tx_byte_d   = tx_byte_q;
    pkt_abort_d = 1'b0;
    last_d      = last_q;
    byte_cnt_d  = byte_cnt_q;
    gap_d       = gap_q;

    case (state_q)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          if (req0_valid & req1_valid) begin
            grant_d = prio_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = req1_valid ? 2'b10 : 2'b01;
          end
          state_d    = SEND;
          byte_cnt_d = 8'd0;
          gap_d      = 16'd0;
        end
      end

      SEND: begin
        if (xfer) begin
          tx_byte_d  = sel_byte;
          tx_start_d = 1'b1;
          last_d     = sel_last;
          byte_cnt_d = byte_cnt_q + 8'd1;
          gap_d      = 16'd0;
          state_d    = WAIT_ACC;
        end else if (!sel_valid) begin
          // Only a silent requester ages the gap; a tx_ready stall does not.
          if (gap_q >= GapLimC) begin
            pkt_abort_d = 1'b1;
            state_d     = IDLE;
            grant_d     = 2'b00;
            byte_cnt_d  = 8'd0;
            gap_d       = 16'd0;
            prio_d      = grant_q[0];
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end

      WAIT_ACC: begin
        if (tx_accept) begin
          tx_start_d = 1'b0;
          // last and the length limit coinciding still yields one release.
          if (last_q || (byte_cnt_q == MaxLenC)) begin
            state_d    = IDLE;
            grant_d    = 2'b00;
            byte_cnt_d = 8'd0;
            gap_d      = 16'd0;
            prio_d     = grant_q[0];
          end else begin
            state_d = SEND;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      prio_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      pkt_abort_q <= 1'b0;
      last_q      <= 1'b0;
      byte_cnt_q  <= 8'd0;
      gap_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      tx_start_q  <= tx_start_d;
      tx_byte_q   <= tx_byte_d;
      pkt_abort_q <= pkt_abort_d;
      last_q      <= last_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Purpose : directed bench for uart_tx_arb with a scoreboard of expected grants and transmitted bytes.
// Latency : transmitter model pulses tx_accept three cycles after a byte load appears.
// Backpres: tx_ready is driven by the stimulus; the model only answers tx_start.
module tb_uart_tx_arb;

  localparam int MAXL    = 4;
  localparam int GAPM    = 8;
  localparam int ACC_DLY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_byte, req1_byte;
  logic       req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_accept;
  logic [1:0] grant;
  logic       pkt_abort;

  logic acc_model, acc_stray, acc_en;
  assign tx_accept = acc_model | acc_stray;

  always #5 clk = ~clk;

  uart_tx_arb #(.MAX_LEN(MAXL), .GAP_MAX(GAPM)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_byte  (req0_byte),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_byte  (req1_byte),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .tx_ready   (tx_ready),
    .tx_accept  (tx_accept),
    .grant      (grant),
    .pkt_abort  (pkt_abort)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];   // {grant, byte} per byte load
  logic [1:0] exp_g[$];   // grant per new ownership
  int         zrun_q[$];  // idle-grant cycles preceding each new ownership

  int cyc = 0, rdy0_cnt = 0, abort_cnt = 0, abort_cyc = 0, last_acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: answer each byte load with a one-cycle accept.
  initial begin
    int acc_cnt;
    acc_model = 1'b0;
    acc_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst || !acc_en) begin
        acc_model = 1'b0;
        acc_cnt   = 0;
      end else if (acc_model) begin
        acc_model = 1'b0;
        acc_cnt   = 0;
      end else if (tx_start) begin
        acc_cnt++;
        if (acc_cnt == ACC_DLY) acc_model = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every new byte load and ownership change.
  initial begin
    logic [9:0] e;
    logic [1:0] g;
    logic       prev_start, prev_abort;
    logic [1:0] prev_grant;
    int         zrun;
    prev_start = 1'b0; prev_abort = 1'b0; prev_grant = 2'b00; zrun = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_start = 1'b0; prev_abort = 1'b0; prev_grant = 2'b00; zrun = 0;
        continue;
      end
      if (req0_ready) rdy0_cnt++;
      if (grant != 2'b00)
        chk("ready_vs_grant", 32'({req1_ready, req0_ready} & ~grant), 32'd0);
      if (tx_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_start", 32'({grant, tx_byte}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant", 32'(grant), 32'(e[9:8]));
          chk("sb_byte", 32'(tx_byte), 32'(e[7:0]));
        end
      end
      if (prev_start && tx_accept) begin
        chk("start_drop_after_accept", 32'(tx_start), 32'd0);
        last_acc_cyc = cyc;
      end
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        zrun_q.push_back(zrun);
        zrun = 0;
        if (exp_g.size() == 0) begin
          chk("gnt_unexpected", 32'(grant), 32'd0);
        end else begin
          g = exp_g.pop_front();
          chk("gnt_seq", 32'(grant), 32'(g));
        end
      end else if (grant == 2'b00) begin
        zrun++;
      end
      if (grant != 2'b00 && prev_grant != 2'b00 && grant != prev_grant)
        chk("gnt_no_idle_gap", 32'(grant), 32'(prev_grant));
      if (pkt_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
        chk("abort_grant", 32'(grant), 32'd0);
      end
      if (prev_abort) chk("abort_width", 32'(pkt_abort), 32'd0);
      prev_start = tx_start;
      prev_abort = pkt_abort;
      prev_grant = grant;
    end
  end

  // Present one byte on requester n and return on the negedge after it is taken.
  task automatic drive(input int n, input logic [7:0] b, input logic l);
    int   t;
    logic rdy;
    t = 0;
    if (n == 0) begin req0_valid = 1'b1; req0_byte = b; req0_last = l; end
    else        begin req1_valid = 1'b1; req1_byte = b; req1_last = l; end
    rdy = (n == 0) ? req0_ready : req1_ready;
    while (!rdy && t < 400) begin
      @(negedge clk);
      t++;
      rdy = (n == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) chk("drive_ready_timeout", 32'(rdy), 32'd1);
    @(negedge clk);
    if (n == 0) begin req0_valid = 1'b0; req0_last = 1'b0; end
    else        begin req1_valid = 1'b0; req1_last = 1'b0; end
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int t;
    t = 0;
    while (grant != g && t < 200) begin @(negedge clk); t++; end
    if (grant != g) chk("wait_grant_timeout", 32'(grant), 32'(g));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_g.size() != 0 || grant != 2'b00 || tx_start) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      chk("idle_timeout_grant", 32'(grant), 32'd0);
      chk("idle_timeout_start", 32'(tx_start), 32'd0);
      chk("idle_timeout_sb", 32'(exp_q.size() + exp_g.size()), 32'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, b0, r0;
    rst = 1'b1; tx_ready = 1'b1; acc_en = 1'b1; acc_stray = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_byte = 8'h00; req1_byte = 8'h00; req0_last = 1'b0; req1_last = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with valids high to show ready stays low under reset.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_tx_byte", 32'(tx_byte), 32'd0);
    chk("reset_abort", 32'(pkt_abort), 32'd0);
    chk("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Contention from reset: 1-byte packets alternate starting with req0.
    exp_g.push_back(2'b01); exp_g.push_back(2'b10); exp_g.push_back(2'b01); exp_g.push_back(2'b10);
    exp_q.push_back({2'b01, 8'hA0}); exp_q.push_back({2'b10, 8'hB0});
    exp_q.push_back({2'b01, 8'hA1}); exp_q.push_back({2'b10, 8'hB1});
    rst = 1'b0;
    fork
      begin drive(0, 8'hA0, 1'b1); drive(0, 8'hA1, 1'b1); end
      begin drive(1, 8'hB0, 1'b1); drive(1, 8'hB1, 1'b1); end
    join
    wait_idle();
    chk("contention_grants", 32'(zrun_q.size()), 32'd4);
    if (zrun_q.size() == 4)
      for (int i = 1; i < 4; i++) chk("contention_idle_gap", 32'(zrun_q[i]), 32'd1);

    // Stray accept in IDLE does nothing.
    acc_stray = 1'b1;
    @(negedge clk);
    acc_stray = 1'b0;
    chk("stray_acc_grant", 32'(grant), 32'd0);
    chk("stray_acc_start", 32'(tx_start), 32'd0);

    // Single packet from req0: 55, A3(last).
    r0 = rdy0_cnt;
    exp_g.push_back(2'b01);
    exp_q.push_back({2'b01, 8'h55}); exp_q.push_back({2'b01, 8'hA3});
    drive(0, 8'h55, 1'b0);
    drive(0, 8'hA3, 1'b1);
    wait_idle();
    chk("single_ready_pulses", 32'(rdy0_cnt - r0), 32'd2);

    // Length limit: req1 streams six bytes, forced release after four, req0 slips in.
    exp_g.push_back(2'b10); exp_g.push_back(2'b01); exp_g.push_back(2'b10);
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, 8'(32'hC1 + i)});
    exp_q.push_back({2'b01, 8'hD0});
    exp_q.push_back({2'b10, 8'hC5}); exp_q.push_back({2'b10, 8'hC6});
    fork
      begin for (int i = 0; i < 6; i++) drive(1, 8'(32'hC1 + i), (i == 5)); end
      begin wait_grant(2'b10); drive(0, 8'hD0, 1'b1); end
    join
    wait_idle();

    // Gap timeout: one byte without last, then silence.
    a0 = abort_cnt;
    exp_g.push_back(2'b01);
    exp_q.push_back({2'b01, 8'hE0});
    drive(0, 8'hE0, 1'b0);
    begin
      int t;
      t = 0;
      while (abort_cnt == a0 && t < 100) begin @(negedge clk); t++; end
    end
    chk("gap_abort_seen", 32'(abort_cnt - a0), 32'd1);
    chk("gap_abort_delay", 32'(abort_cyc - last_acc_cyc), 32'(GAPM));
    chk("gap_abort_pulse", 32'(pkt_abort), 32'd1);
    chk("gap_abort_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("gap_abort_one_cycle", 32'(pkt_abort), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("gap_no_start", 32'(tx_start), 32'd0);
    end
    wait_idle();

    // Backpressure: tx_ready low for 20 cycles while req0 holds valid.
    b0 = abort_cnt;
    exp_g.push_back(2'b01);
    exp_q.push_back({2'b01, 8'hF0});
    tx_ready = 1'b0;
    req0_valid = 1'b1; req0_byte = 8'hF0; req0_last = 1'b1;
    @(negedge clk);
    chk("bp_grant", 32'(grant), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_ready", 32'(req0_ready), 32'd0);
      acc_stray = (i == 10);
      @(negedge clk);
    end
    acc_stray = 1'b0;
    chk("bp_no_abort", 32'(abort_cnt - b0), 32'd0);
    chk("bp_no_start", 32'(tx_start), 32'd0);
    tx_ready = 1'b1;
    #1;
    chk("bp_ready_first", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req0_last = 1'b0;
    chk("bp_start", 32'(tx_start), 32'd1);
    wait_idle();

    // Reset during WAIT_ACC, then confirm req0 priority restored.
    acc_en = 1'b0;
    exp_g.push_back(2'b01);
    exp_q.push_back({2'b01, 8'h77});
    drive(0, 8'h77, 1'b0);
    chk("rst_pre_start", 32'(tx_start), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_start", 32'(tx_start), 32'd0);
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_byte", 32'(tx_byte), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acc_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_replay", 32'(tx_start), 32'd0);
      chk("rst_idle_grant", 32'(grant), 32'd0);
    end
    exp_g.push_back(2'b01); exp_g.push_back(2'b10);
    exp_q.push_back({2'b01, 8'h88}); exp_q.push_back({2'b10, 8'h99});
    fork
      drive(0, 8'h88, 1'b1);
      drive(1, 8'h99, 1'b1);
    join
    wait_idle();

    chk("sb_empty", 32'(exp_q.size() + exp_g.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
